// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op and state encodings shared by the multiply/divide unit
// and whoever drives it.
//   MD_ITER    iteration count for a 32-bit operand
//   md_op_e    3-bit op code carried on the op port
//   md_state_e FSM states of the iterative unit
package muldiv_pkg;

   localparam int MD_ITER = 32;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } md_state_e;

   // Codes 6 and 7 are undefined.
   function automatic logic md_op_valid(input logic [2:0] op);
      return op <= 3'(MD_MTLO);
   endfunction

   function automatic logic md_op_signed(input logic [2:0] op);
      return (op == 3'(MD_MULT)) || (op == 3'(MD_DIV));
   endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: issue/result bundle between the execute stage and muldiv.
//   start/op/num1/num2      issue side, driven by the pipeline (master)
//   busy/hi/lo              unit status and architectural HI/LO
//   div_by_zero/op_invalid  status flags
interface muldiv_if;
   logic        start;
   logic [2:0]  op;
   logic [31:0] num1;
   logic [31:0] num2;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        div_by_zero;
   logic        op_invalid;

   modport master (
      output start, op, num1, num2,
      input  busy, hi, lo, div_by_zero, op_invalid
   );

   modport slave (
      input  start, op, num1, num2,
      output busy, hi, lo, div_by_zero, op_invalid
   );
endinterface

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: conditional two's-complement negate.
//   val  operand
//   neg  1 = return -val, 0 = pass through
//   res  result, same width
// Used as abs() at accept (neg = operand sign) and as the final sign
// correction in FIX. abs(0x8000_0000) stays 0x8000_0000, which is the
// correct unsigned magnitude.
module muldiv_sign_fix #(
   parameter int W = 32
) (
   input  logic [W-1:0] val,
   input  logic         neg,
   output logic [W-1:0] res
);
   assign res = neg ? (~val + W'(1)) : val;
endmodule

// File: rtl/muldiv.sv
// muldiv: iterative multiply/divide unit owning HI/LO.
//   clk, reset_n  clock, synchronous active-low reset
//   bus           muldiv_if.slave: start/op/num1/num2 in,
//                 busy/hi/lo/div_by_zero/op_invalid out
// MULT/MULTU run a shift-add multiply, DIV/DIVU a restoring divide, both on
// operand magnitudes for ITER cycles, followed by one FIX cycle that applies
// sign correction and writes HI/LO.
module muldiv
   import muldiv_pkg::*;
#(
   parameter int ITER = MD_ITER
) (
   input  logic     clk,
   input  logic     reset_n,
   muldiv_if.slave  bus
);
   localparam int CW = $clog2(ITER);

   md_state_e   state_q, state_d;
   logic [CW-1:0] cnt_q;
   logic [63:0] acc_q;     // MUL: {partial product, multiplier}; DIV: [31:0] dividend->quotient
   logic [31:0] rem_q;     // DIV partial remainder (always < divisor, so 32 bits hold it)
   logic [31:0] opa_q;     // multiplicand or divisor magnitude
   logic [31:0] n1_q;      // raw dividend, returned as HI on divide-by-zero
   logic        neg_res_q, neg_rem_q, dz_q, is_div_q;
   logic [31:0] hi_q, lo_q;
   logic        dbz_q, inv_q;
   logic        busy;

   logic        sgn;
   logic [31:0] abs1, abs2;
   logic [32:0] mul_sum;
   logic [32:0] div_sh;
   logic        div_ge;
   logic [31:0] rem_next;
   logic [63:0] prod_fix;
   logic [31:0] quo_fix, rem_fix;

   assign sgn = md_op_signed(bus.op);

   muldiv_sign_fix #(.W(32)) u_abs1 (.val(bus.num1), .neg(sgn & bus.num1[31]), .res(abs1));
   muldiv_sign_fix #(.W(32)) u_abs2 (.val(bus.num2), .neg(sgn & bus.num2[31]), .res(abs2));
   muldiv_sign_fix #(.W(64)) u_prod (.val(acc_q),        .neg(neg_res_q), .res(prod_fix));
   muldiv_sign_fix #(.W(32)) u_quo  (.val(acc_q[31:0]),  .neg(neg_res_q), .res(quo_fix));
   muldiv_sign_fix #(.W(32)) u_rem  (.val(rem_q),        .neg(neg_rem_q), .res(rem_fix));

   // One multiplier bit per cycle: add on LSB, shift the 64-bit accumulator right.
   assign mul_sum = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opa_q : 32'd0)};

   // Restoring step: bring in next dividend bit, subtract if it fits.
   // The true difference is < divisor, so 32-bit modular subtraction is exact.
   assign div_sh   = {rem_q, acc_q[31]};
   assign div_ge   = div_sh >= {1'b0, opa_q};
   assign rem_next = div_ge ? (div_sh[31:0] - opa_q) : div_sh[31:0];

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (bus.start) begin
            if (bus.op == 3'(MD_MULT) || bus.op == 3'(MD_MULTU)) state_d = ST_MUL;
            else if (bus.op == 3'(MD_DIV) || bus.op == 3'(MD_DIVU)) state_d = ST_DIV;
         end
         ST_MUL, ST_DIV: if (cnt_q == CW'(ITER - 1)) state_d = ST_FIX;
         ST_FIX:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      busy = (state_q != ST_IDLE);
   end

   // Datapath and architectural state
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q     <= '0;
         acc_q     <= '0;
         rem_q     <= '0;
         opa_q     <= '0;
         n1_q      <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
         is_div_q  <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         dbz_q     <= 1'b0;
         inv_q     <= 1'b0;
      end else begin
         inv_q <= 1'b0;
         case (state_q)
            ST_IDLE: if (bus.start) begin
               inv_q <= !md_op_valid(bus.op);
               if (md_op_valid(bus.op)) dbz_q <= 1'b0;
               cnt_q     <= '0;
               neg_res_q <= sgn & (bus.num1[31] ^ bus.num2[31]);
               neg_rem_q <= sgn & bus.num1[31];
               n1_q      <= bus.num1;
               case (bus.op)
                  3'(MD_MTHI): hi_q <= bus.num1;
                  3'(MD_MTLO): lo_q <= bus.num1;
                  3'(MD_MULT), 3'(MD_MULTU): begin
                     acc_q    <= {32'd0, abs2};
                     opa_q    <= abs1;
                     is_div_q <= 1'b0;
                  end
                  3'(MD_DIV), 3'(MD_DIVU): begin
                     acc_q    <= {32'd0, abs1};
                     opa_q    <= abs2;
                     rem_q    <= '0;
                     dz_q     <= (bus.num2 == 32'd0);
                     is_div_q <= 1'b1;
                  end
                  default: ;
               endcase
            end
            ST_MUL: begin
               acc_q <= {mul_sum, acc_q[31:1]};
               cnt_q <= cnt_q + CW'(1);
            end
            ST_DIV: begin
               acc_q[31:0] <= {acc_q[30:0], div_ge};
               rem_q       <= rem_next;
               cnt_q       <= cnt_q + CW'(1);
            end
            ST_FIX: begin
               if (!is_div_q) begin
                  hi_q <= prod_fix[63:32];
                  lo_q <= prod_fix[31:0];
               end else if (dz_q) begin
                  // Fixed result, no sign correction.
                  hi_q  <= n1_q;
                  lo_q  <= 32'hFFFF_FFFF;
                  dbz_q <= 1'b1;
               end else begin
                  hi_q <= rem_fix;
                  lo_q <= quo_fix;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy        = busy;
   assign bus.hi          = hi_q;
   assign bus.lo          = lo_q;
   assign bus.div_by_zero = dbz_q;
   assign bus.op_invalid  = inv_q;

endmodule

// File: tb/tb_muldiv.sv
// tb_muldiv: directed vectors; expected HI/LO/div_by_zero pushed into a
// scoreboard at issue, a monitor pops and compares on every busy fall.
module tb_muldiv;
   import muldiv_pkg::*;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
      string       name;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   tests = 0;
   int   fails = 0;
   exp_t exp_q[$];

   muldiv_if bus ();

   muldiv #(.ITER(MD_ITER)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: result check on every busy 1->0 outside reset.
   logic busy_d = 1'b0;
   int   bcnt = 0;
   always @(negedge clk) begin
      if (!reset_n) begin
         busy_d = 1'b0;
         bcnt   = 0;
      end else begin
         if (bus.busy) bcnt++;
         if (busy_d && !bus.busy) begin
            if (exp_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL scoreboard: unexpected completion hi=%h lo=%h", bus.hi, bus.lo);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk({e.name, " hi"}, bus.hi, e.hi);
               chk({e.name, " lo"}, bus.lo, e.lo);
               chk({e.name, " div_by_zero"}, 32'(bus.div_by_zero), 32'(e.dbz));
               chk({e.name, " busy cycles"}, 32'(bcnt), 32'd33);
            end
            bcnt = 0;
         end
         busy_d = bus.busy;
      end
   end

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      bus.start = 1'b1; bus.op = op; bus.num1 = a; bus.num2 = b;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (bus.busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (bus.busy) begin
         tests++; fails++;
         $display("FAIL %s timeout: busy still 1 after %0d cycles", name, n);
      end
   endtask

   task automatic run_md(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                         input logic edz);
      exp_t e;
      e.hi = ehi; e.lo = elo; e.dbz = edz; e.name = name;
      exp_q.push_back(e);
      issue(op, a, b);
      wait_idle(name);
   endtask

   initial begin
      bus.start = 1'b0; bus.op = 3'd0; bus.num1 = '0; bus.num2 = '0;
      repeat (2) @(negedge clk);
      chk("reset hi", bus.hi, 32'd0);
      chk("reset lo", bus.lo, 32'd0);
      chk("reset busy", 32'(bus.busy), 32'd0);
      chk("reset dbz", 32'(bus.div_by_zero), 32'd0);
      chk("reset op_invalid", 32'(bus.op_invalid), 32'd0);
      reset_n = 1'b1;

      // Moves to HI/LO take effect at the accept edge, never busy.
      issue(3'(MD_MTHI), 32'hDEAD_BEEF, 32'd0);
      chk("mthi hi", bus.hi, 32'hDEAD_BEEF);
      chk("mthi busy", 32'(bus.busy), 32'd0);
      issue(3'(MD_MTLO), 32'h0000_0055, 32'd0);
      chk("mtlo lo", bus.lo, 32'h0000_0055);

      // Undefined op: one-cycle pulse, nothing else changes.
      issue(3'b111, 32'h1111_1111, 32'h2222_2222);
      chk("inv pulse", 32'(bus.op_invalid), 32'd1);
      chk("inv busy", 32'(bus.busy), 32'd0);
      chk("inv hi", bus.hi, 32'hDEAD_BEEF);
      chk("inv lo", bus.lo, 32'h0000_0055);
      @(negedge clk);
      chk("inv pulse end", 32'(bus.op_invalid), 32'd0);

      run_md("multu max", 3'(MD_MULTU), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);

      // HI/LO hold old value during busy; operand changes are ignored.
      begin
         exp_t e;
         e.hi = 32'hFFFF_FFFF; e.lo = 32'hFFFF_FFEB; e.dbz = 1'b0; e.name = "mult -3*7";
         exp_q.push_back(e);
         issue(3'(MD_MULT), 32'hFFFF_FFFD, 32'd7);
         bus.num1 = 32'h1234_5678; bus.num2 = 32'h9ABC_DEF0;
         repeat (10) @(negedge clk);
         chk("mult busy hi hold", bus.hi, 32'hFFFF_FFFE);
         chk("mult busy lo hold", bus.lo, 32'h0000_0001);
         chk("mult busy", 32'(bus.busy), 32'd1);
         wait_idle("mult -3*7");
      end

      run_md("mult min*min", 3'(MD_MULT), 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
      run_md("div -7/2", 3'(MD_DIV), 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      run_md("div 7/-2", 3'(MD_DIV), 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
      run_md("divu 100/7", 3'(MD_DIVU), 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
      run_md("div ovf", 3'(MD_DIV), 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
      run_md("divu 7/0", 3'(MD_DIVU), 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 1'b1);
      issue(3'(MD_MTLO), 32'h0000_0042, 32'd0);
      chk("mtlo clears dbz", 32'(bus.div_by_zero), 32'd0);
      chk("mtlo after dz lo", bus.lo, 32'h0000_0042);

      // Starts while busy are dropped, including MTHI and undefined ops.
      begin
         exp_t e;
         e.hi = 32'd0; e.lo = 32'd6; e.dbz = 1'b0; e.name = "mult 2*3 ignored starts";
         exp_q.push_back(e);
         issue(3'(MD_MULT), 32'd2, 32'd3);
         repeat (3) @(negedge clk);
         bus.start = 1'b1; bus.op = 3'(MD_MTHI); bus.num1 = 32'h0000_1234;
         @(negedge clk);
         chk("busy mthi ignored", bus.hi, 32'd7);
         bus.op = 3'(MD_MULTU); bus.num1 = 32'd9; bus.num2 = 32'd9;
         @(negedge clk);
         bus.op = 3'b111;
         @(negedge clk);
         chk("busy no op_invalid", 32'(bus.op_invalid), 32'd0);
         bus.start = 1'b0;
         wait_idle("mult 2*3 ignored starts");
      end
      @(negedge clk);
      chk("no extra start", 32'(bus.busy), 32'd0);

      // Mid-operation reset aborts without writing HI/LO.
      issue(3'(MD_MULT), 32'd5, 32'd5);
      repeat (8) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      chk("abort busy", 32'(bus.busy), 32'd0);
      chk("abort hi", bus.hi, 32'd0);
      chk("abort lo", bus.lo, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      run_md("multu after reset", 3'(MD_MULTU), 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);
      repeat (2) @(negedge clk);
      chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
